pwm_fifo_reader: RTL and testbench

PWM_FIFO_READER -- requirements
Module: pwm_fifo_reader

---
 rtl/pwm_fifo_reader_if.sv | 13 +
 rtl/pwm_fifo_reader.sv | 75 +++++++
 tb/tb_pwm_fifo_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pwm_fifo_reader_if.sv
// pwm_fifo_reader_if: read-side handshake between a sync FIFO and the PWM reader
//   i_fifo       FIFO read data, valid the cycle after o_re
//   i_fifo_empty FIFO empty flag
//   o_re         one-cycle read enable issued by the reader
interface pwm_fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_fifo;
    logic             i_fifo_empty;
    logic             o_re;
    modport master (input i_fifo, input i_fifo_empty, output o_re);
    modport slave (output i_fifo, output i_fifo_empty, input o_re);
endinterface

// File: rtl/pwm_fifo_reader.sv
// pwm_fifo_reader: PWM generator whose duty samples are prefetched from a sync FIFO
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_en          PWM run enable (fetching continues while low)
//   fifo          FIFO read port (master side)
//   o_pwm         registered PWM output
//   o_duty        duty value in use for the current period
//   o_period_end  high in the last cycle of each enabled period
//   o_underrun    high in a period-end cycle with no staged sample
module pwm_fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    pwm_fifo_reader_if.master   fifo,
    output logic                o_pwm,
    output logic [WIDTH-1:0]    o_duty,
    output logic                o_period_end,
    output logic                o_underrun
);
    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] stg_q, stg_d;
    logic             sv_q, sv_d;
    logic             pwm_q, pwm_d;
    // holds off the first read by one cycle after reset release
    logic             arm_q, arm_d;
    assign o_period_end = i_en && (cnt_q == '1);
    assign o_underrun   = o_period_end && !sv_q;
    assign o_pwm        = pwm_q;
    assign o_duty       = duty_q;
    assign fifo.o_re    = (state_q == REQ);
    always_comb begin
        state_d = state_q;
        arm_d   = 1'b1;
        cnt_d   = i_en ? cnt_q + 1'b1 : '0;
        pwm_d   = i_en && (cnt_q < duty_q);
        duty_d  = (o_period_end && sv_q) ? stg_q : duty_q;
        stg_d   = stg_q;
        sv_d    = (o_period_end && sv_q) ? 1'b0 : sv_q;
        // a sample can only be captured while nothing is staged, so the
        // capture never collides with the boundary load above
        case (state_q)
            IDLE:    state_d = (arm_q && !sv_q && !fifo.i_fifo_empty) ? REQ : IDLE;
            REQ:     state_d = CAPT;
            CAPT: begin
                state_d = IDLE;
                stg_d   = fifo.i_fifo;
                sv_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            duty_q  <= '0;
            stg_q   <= '0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            stg_q   <= stg_d;
            sv_q    <= sv_d;
        end
    end
endmodule

// File: tb/tb_pwm_fifo_reader.sv
// tb_pwm_fifo_reader: directed self-checking bench for pwm_fifo_reader at WIDTH=4
module tb_pwm_fifo_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pwm;
    logic [3:0] duty;
    logic       pe;
    logic       ur;
    logic [3:0] mem[$];
    int         n_checks = 0;
    int         n_errors = 0;
    pwm_fifo_reader_if #(.WIDTH(4)) ifc ();
    pwm_fifo_reader #(.WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .fifo         (ifc),
        .o_pwm        (pwm),
        .o_duty       (duty),
        .o_period_end (pe),
        .o_underrun   (ur)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // one clock; the FIFO model pops on an edge where o_re was high
    task automatic tick();
        logic re_was;
        re_was = ifc.o_re;
        @(posedge clk);
        #1;
        if (re_was) ifc.i_fifo = mem.pop_front();
        ifc.i_fifo_empty = (mem.size() == 0);
    endtask
    task automatic push(input logic [3:0] v);
        mem.push_back(v);
        ifc.i_fifo_empty = 1'b0;
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, " re"}, ifc.o_re, 0);
        check({tag, " pwm"}, pwm, 0);
        check({tag, " duty"}, duty, 0);
        check({tag, " pe"}, pe, 0);
        check({tag, " ur"}, ur, 0);
    endtask
    // observes one 16-cycle period starting at counter 0
    task automatic run_period(input string tag, input int exp_duty, input int exp_hi,
                              input int exp_ur, input int exp_re);
        int   n_hi, n_pe, n_ur, n_re;
        logic pe15;
        n_hi = 0; n_pe = 0; n_ur = 0; n_re = 0; pe15 = 1'b0;
        check({tag, " duty"}, duty, exp_duty);
        for (int i = 0; i < 16; i++) begin
            n_hi += int'(pwm);
            n_pe += int'(pe);
            n_ur += int'(ur);
            n_re += int'(ifc.o_re);
            if (i == 15) pe15 = pe;
            tick();
        end
        check({tag, " hi"}, n_hi, exp_hi);
        check({tag, " pe_last"}, pe15, 1);
        check({tag, " pe_cnt"}, n_pe, 1);
        check({tag, " ur"}, n_ur, exp_ur);
        check({tag, " re"}, n_re, exp_re);
    endtask
    initial begin
        int n;
        ifc.i_fifo = '0;
        ifc.i_fifo_empty = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        tick();
        tick();
        check_idle_outputs("rst_hold");
        push(4'd8);
        tick();
        check("rst_with_data re", ifc.o_re, 0);
        rst = 1'b0;
        tick();
        check("release edge1 re", ifc.o_re, 0);
        tick();
        check("release edge2 re", ifc.o_re, 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(ifc.o_re);
        end
        check("prefetch single re", n, 0);
        check("prefetch duty", duty, 0);
        check("prefetch pwm", pwm, 0);
        en = 1'b1;
        run_period("p1", 0, 0, 0, 0);
        run_period("p2", 8, 8, 1, 0);
        push(4'd0);
        push(4'd15);
        push(4'd3);
        run_period("p3", 8, 8, 0, 1);
        run_period("p4", 0, 0, 0, 1);
        run_period("p5", 15, 15, 0, 1);
        push(4'd12);
        run_period("p6", 3, 3, 0, 1);
        push(4'd5);
        check("p7 duty", duty, 12);
        for (int i = 0; i < 7; i++) tick();
        check("p7 cnt7 pwm", pwm, 1);
        en = 1'b0;
        tick();
        check("en_drop pwm", pwm, 0);
        check("en_drop ur", ur, 0);
        check("en_drop duty", duty, 12);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n += int'(pwm) + int'(pe) + int'(ur);
            tick();
        end
        check("en_low quiet", n, 0);
        en = 1'b1;
        run_period("p8", 12, 12, 0, 0);
        run_period("p9", 5, 5, 1, 0);
        push(4'd9);
        tick();
        check("pre_rst re", ifc.o_re, 1);
        check("pre_rst pwm", pwm, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_in_req");
        tick();
        tick();
        check("rst_in_req fifo kept", mem.size(), 1);
        rst = 1'b0;
        tick();
        check("resume edge1 re", ifc.o_re, 0);
        tick();
        check("resume edge2 re", ifc.o_re, 1);
        for (int i = 0; i < 13; i++) tick();
        check("resume pe", pe, 1);
        check("resume ur", ur, 0);
        check("resume duty before", duty, 0);
        tick();
        check("resume duty after", duty, 9);
        check("resume fifo drained", mem.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
